frame_reader: RTL

- Read-side counterpart of the camera capture/write path: drains SDRAM read FIFO sides 1 and 2 for one stored frame.
- Rebuilds 30-bit RGB pixels from the split word format used on the write side: side1 = {0, G[9:5], B[9:0]}, side2 = {0, G[4:0], R[9:0]}.
- Presents pixels as a valid/ready stream with x/y coordinates and framing flags to the downstream display/processing stage.

---
 rtl/frame_reader_pkg.sv | 31 +++
 rtl/frame_reader_px_out_fifo.sv | 49 ++++
 rtl/frame_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/frame_reader_pkg.sv
// Shared types for the frame read path: FSM encoding, RGB pixel and output FIFO entry.
package frame_reader_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb_t;

    // 58-bit output FIFO entry: colour plus the coordinates it was captured at
    typedef struct packed {
        rgb_t        rgb;
        logic [11:0] x;
        logic [15:0] y;
    } px_t;

    // side1 = {G[9:5], B}, side2 = {G[4:0], R}; bit 15 never reaches here
    function automatic rgb_t unpack(input logic [14:0] s1, input logic [14:0] s2);
        rgb_t p;
        p.r = s2[9:0];
        p.g = {s1[14:10], s2[14:10]};
        p.b = s1[9:0];
        return p;
    endfunction

endpackage

// File: rtl/frame_reader_px_out_fifo.sv
// Three-entry pixel buffer between the SDRAM read FIFOs and the downstream stream.
module px_out_fifo
    import frame_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  px_t        din,
    output logic       valid,
    input  logic       ready,
    output px_t        dout,
    output logic [1:0] count
);

    px_t        mem [3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       pop;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Drains both SDRAM read FIFO sides for one frame and streams rebuilt RGB pixels with x/y.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int          H_ACTIVE    = 160,
    parameter int          V_ACTIVE    = 120,
    parameter logic [15:0] BASE1       = 16'h0000,
    parameter logic [15:0] BASE2       = 16'h8000,
    parameter logic [7:0]  BURST_LEN   = 8'd128,
    parameter int          LOAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] RD1_DATA,
    input  logic        RD1_EMPTY,
    output logic        RD1,
    output logic [15:0] RD1_ADDR,
    output logic [15:0] RD1_MAX_ADDR,
    output logic [7:0]  RD1_LENGTH,
    output logic        RD1_LOAD,
    input  logic [15:0] RD2_DATA,
    input  logic        RD2_EMPTY,
    output logic        RD2,
    output logic [15:0] RD2_ADDR,
    output logic [15:0] RD2_MAX_ADDR,
    output logic [7:0]  RD2_LENGTH,
    output logic        RD2_LOAD,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [9:0]  px_r,
    output logic [9:0]  px_g,
    output logic [9:0]  px_b,
    output logic [11:0] px_x,
    output logic [15:0] px_y,
    output logic        px_sof,
    output logic        px_eol,
    output logic        frame_done,
    output logic        busy
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;

    logic [1:0]  state;
    logic [7:0]  load_cnt;
    logic [15:0] pops;
    logic [15:0] accepted;
    logic        inflight;
    logic [11:0] wx;
    logic [15:0] wy;
    logic [1:0]  buf_count;
    logic        pop_ok;
    logic        xfer;
    px_t         din;
    px_t         head;
    logic        unused_msb;

    assign RD1_ADDR     = BASE1;
    assign RD2_ADDR     = BASE2;
    assign RD1_MAX_ADDR = BASE1 + 16'(TOTAL);
    assign RD2_MAX_ADDR = BASE2 + 16'(TOTAL);
    assign RD1_LENGTH   = BURST_LEN;
    assign RD2_LENGTH   = BURST_LEN;

    // Both sides pop together; at most 3 pixels buffered or in flight after a pop
    assign pop_ok = (state == ST_STREAM) && !RD1_EMPTY && !RD2_EMPTY &&
                    (pops < 16'(TOTAL)) &&
                    (({1'b0, buf_count} + {2'b0, inflight}) <= 3'd2);
    assign RD1 = pop_ok;
    assign RD2 = pop_ok;

    assign RD1_LOAD   = (state == ST_LOAD);
    assign RD2_LOAD   = (state == ST_LOAD);
    assign frame_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    assign din        = '{rgb: unpack(RD1_DATA[14:0], RD2_DATA[14:0]), x: wx, y: wy};
    assign unused_msb = RD1_DATA[15] ^ RD2_DATA[15];
    assign xfer       = px_valid && px_ready;

    px_out_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (state == ST_LOAD),
        .push  (inflight),
        .din   (din),
        .valid (px_valid),
        .ready (px_ready),
        .dout  (head),
        .count (buf_count)
    );

    assign px_r   = head.rgb.r;
    assign px_g   = head.rgb.g;
    assign px_b   = head.rgb.b;
    assign px_x   = head.x;
    assign px_y   = head.y;
    assign px_sof = px_valid && (head.x == 12'd0) && (head.y == 16'd0);
    assign px_eol = px_valid && (head.x == 12'(H_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            pops     <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            wx       <= '0;
            wy       <= '0;
        end else begin
            inflight <= pop_ok;
            if (pop_ok) pops <= pops + 16'd1;
            // Coordinates are stamped on each captured word, in pop order
            if (inflight) begin
                if (wx == 12'(H_ACTIVE - 1)) begin
                    wx <= '0;
                    wy <= wy + 16'd1;
                end else begin
                    wx <= wx + 12'd1;
                end
            end
            case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_LOAD;
                    load_cnt <= '0;
                    pops     <= '0;
                    accepted <= '0;
                    wx       <= '0;
                    wy       <= '0;
                end
                ST_LOAD: begin
                    if (load_cnt == 8'(LOAD_CYCLES - 1)) state <= ST_STREAM;
                    else load_cnt <= load_cnt + 8'd1;
                end
                ST_STREAM: if (xfer) begin
                    accepted <= accepted + 16'd1;
                    if (accepted == 16'(TOTAL - 1)) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
